// File: rtl/ex_muldiv_pkg.sv
// Shared widths, op codes, FSM state encoding and decode helper for the mul/div unit.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MULDIV_MADD_EN.
package ex_muldiv_pkg;

  localparam int unsigned RegBus        = 32;
  localparam int unsigned DoubleBus     = 2 * RegBus;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic        RstEnable     = 1'b1;
  localparam int unsigned DivIterations = 32;
  localparam int unsigned DivCntW       = $clog2(DivIterations);

  typedef enum logic [2:0] {
    MdMult  = 3'd0,
    MdMultu = 3'd1,
    MdDiv   = 3'd2,
    MdDivu  = 3'd3,
    MdMadd  = 3'd4,
    MdMaddu = 3'd5,
    MdMsub  = 3'd6,
    MdMsubu = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMulAcc = 2'd1,
    StDivOn  = 2'd2,
    StFinish = 2'd3
  } md_state_e;

  // Accumulate ops decode as reserved unless the feature is built in.
  function automatic logic md_op_supported(md_op_e op);
`ifdef MULDIV_MADD_EN
    md_op_supported = op inside {MdMult, MdMultu, MdDiv, MdDivu,
                                 MdMadd, MdMaddu, MdMsub, MdMsubu};
`else
    md_op_supported = op inside {MdMult, MdMultu, MdDiv, MdDivu};
`endif
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> mul/div unit signal bundle; master is the execute stage, slave the unit.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic              start;
  logic [2:0]        op;
  logic [RegBus-1:0] opdata1;
  logic [RegBus-1:0] opdata2;
  logic [RegBus-1:0] hi_i;
  logic [RegBus-1:0] lo_i;
  logic              annul;
  logic [RegBus-1:0] result_hi;
  logic [RegBus-1:0] result_lo;
  logic              done;
  logic              stallreq;

  modport master (
    output start, op, opdata1, opdata2, hi_i, lo_i, annul,
    input  result_hi, result_lo, done, stallreq
  );

  modport slave (
    input  start, op, opdata1, opdata2, hi_i, lo_i, annul,
    output result_hi, result_lo, done, stallreq
  );

endinterface

// File: rtl/ex_muldiv_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: 65-bit {rem, quot} work register,
// 33-bit trial subtractor and iteration counter. Step outputs are the post-step values.
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              flush_i,
  input  logic [RegBus-1:0] dividend_i,
  input  logic [RegBus-1:0] divisor_i,
  output logic              last_o,
  output logic [RegBus-1:0] quot_o,
  output logic [RegBus-1:0] rem_o
);

  logic [DoubleBus:0]   work_q;
  logic [DoubleBus:0]   shifted;
  logic [DoubleBus:0]   work_next;
  logic [RegBus:0]      trial;
  logic [RegBus-1:0]    divisor_q;
  logic [DivCntW-1:0]   cnt_q;
  logic                 unused_rem_msb;

  always_comb begin
    shifted   = work_q << 1;
    trial     = shifted[DoubleBus:RegBus] - {1'b0, divisor_q};
    work_next = trial[RegBus] ? shifted : {trial, shifted[RegBus-1:1], 1'b1};
  end

  // Remainder is always below the divisor, so bit 64 is zero after a step.
  assign unused_rem_msb = work_next[DoubleBus];
  assign quot_o         = work_next[RegBus-1:0];
  assign rem_o          = work_next[DoubleBus-1:RegBus];
  assign last_o         = (cnt_q == DivCntW'(DivIterations - 1));

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush_i) begin
      work_q    <= '0;
      divisor_q <= ZeroWord;
      cnt_q     <= '0;
    end else if (load_i) begin
      work_q    <= {{(RegBus + 1){1'b0}}, dividend_i};
      divisor_q <= divisor_i;
      cnt_q     <= '0;
    end else if (step_i) begin
      work_q    <= work_next;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage, stalling IF..EX until done.
// Define MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU and the MUL_ACC state.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave md
);

  md_op_e              op;
  md_state_e           state_q;
  logic                op_ok;
  logic                op_signed;
  logic                is_div;
  logic [DoubleBus-1:0] a_ext;
  logic [DoubleBus-1:0] b_ext;
  logic [DoubleBus-1:0] prod;
  logic [RegBus-1:0]   dividend_mag;
  logic [RegBus-1:0]   divisor_mag;
  logic                div_load;
  logic                div_step;
  logic                div_last;
  logic [RegBus-1:0]   div_quot;
  logic [RegBus-1:0]   div_rem;
  logic                quot_neg_q;
  logic                rem_neg_q;
  logic [RegBus-1:0]   result_hi_q;
  logic [RegBus-1:0]   result_lo_q;
  logic                done_q;
  logic                stall;

`ifdef MULDIV_MADD_EN
  logic [DoubleBus-1:0] prod_q;
  logic                 acc_sub_q;
`else
  logic                 unused_acc;
  assign unused_acc = ^{md.hi_i, md.lo_i};
`endif

  assign op        = md_op_e'(md.op);
  assign op_ok     = md_op_supported(op);
  assign op_signed = op inside {MdMult, MdDiv, MdMadd, MdMsub};
  assign is_div    = op inside {MdDiv, MdDivu};

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact.
  assign a_ext = {{RegBus{op_signed & md.opdata1[RegBus-1]}}, md.opdata1};
  assign b_ext = {{RegBus{op_signed & md.opdata2[RegBus-1]}}, md.opdata2};
  assign prod  = a_ext * b_ext;

  assign dividend_mag = (op_signed && md.opdata1[RegBus-1]) ? ZeroWord - md.opdata1 : md.opdata1;
  assign divisor_mag  = (op_signed && md.opdata2[RegBus-1]) ? ZeroWord - md.opdata2 : md.opdata2;

  assign div_load = (state_q == StIdle) && md.start && !md.annul && is_div &&
                    (md.opdata2 != ZeroWord);
  assign div_step = (state_q == StDivOn) && !md.annul;

  ex_muldiv_div_core u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .flush_i    (md.annul),
    .dividend_i (dividend_mag),
    .divisor_i  (divisor_mag),
    .last_o     (div_last),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= StIdle;
      result_hi_q <= ZeroWord;
      result_lo_q <= ZeroWord;
      done_q      <= 1'b0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
`ifdef MULDIV_MADD_EN
      prod_q      <= '0;
      acc_sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (md.annul) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (md.start && op_ok) begin
              case (op)
                MdMult, MdMultu: begin
                  {result_hi_q, result_lo_q} <= prod;
                  done_q                     <= 1'b1;
                  state_q                    <= StFinish;
                end
`ifdef MULDIV_MADD_EN
                MdMadd, MdMaddu, MdMsub, MdMsubu: begin
                  prod_q    <= prod;
                  acc_sub_q <= op inside {MdMsub, MdMsubu};
                  state_q   <= StMulAcc;
                end
`endif
                MdDiv, MdDivu: begin
                  quot_neg_q <= op_signed & (md.opdata1[RegBus-1] ^ md.opdata2[RegBus-1]);
                  rem_neg_q  <= op_signed & md.opdata1[RegBus-1];
                  if (md.opdata2 == ZeroWord) begin
                    result_hi_q <= ZeroWord;
                    result_lo_q <= ZeroWord;
                    done_q      <= 1'b1;
                    state_q     <= StFinish;
                  end else begin
                    state_q <= StDivOn;
                  end
                end
                default: ;
              endcase
            end
          end
          StMulAcc: begin
`ifdef MULDIV_MADD_EN
            {result_hi_q, result_lo_q} <= acc_sub_q ? {md.hi_i, md.lo_i} - prod_q
                                                    : {md.hi_i, md.lo_i} + prod_q;
            done_q  <= 1'b1;
            state_q <= StFinish;
`else
            state_q <= StIdle;
`endif
          end
          StDivOn: begin
            if (div_last) begin
              result_lo_q <= quot_neg_q ? ZeroWord - div_quot : div_quot;
              result_hi_q <= rem_neg_q ? ZeroWord - div_rem : div_rem;
              done_q      <= 1'b1;
              state_q     <= StFinish;
            end
          end
          StFinish: state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
      end
    end
  end

  // Combinational so the pipeline freezes in the same cycle the op is seen.
  always_comb begin
    stall = 1'b0;
    if (rst != RstEnable && !md.annul) begin
      unique case (state_q)
        StIdle:            stall = md.start && op_ok;
        StMulAcc, StDivOn: stall = 1'b1;
        StFinish:          stall = 1'b0;
        default:           stall = 1'b0;
      endcase
    end
  end

  assign md.stallreq  = stall;
  assign md.done      = done_q;
  assign md.result_hi = result_hi_q;
  assign md.result_lo = result_lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed cases plus random ops against an arithmetic model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  ex_muldiv_if md_if ();

  ex_muldiv u_dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit supported(input md_op_e op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return !op[2];
`endif
  endfunction

  function automatic int latency(input md_op_e op, input logic [31:0] b);
    if (op == MdMult || op == MdMultu) return 1;
    if (op == MdDiv || op == MdDivu) return (b == 0) ? 1 : 33;
    return 2;
  endfunction

  // Reference: plain 64-bit integer arithmetic on the architectural values.
  function automatic logic [63:0] model(input md_op_e op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint sa, sb2, q, r;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {hi, lo};
    case (op)
      MdMult:  return sa * sb2;
      MdMultu: return ua * ub;
      MdDiv: begin
        if (b == 0) return 64'd0;
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      MdDivu: begin
        if (b == 0) return 64'd0;
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
      MdMadd:  return acc + 64'(sa * sb2);
      MdMaddu: return acc + ua * ub;
      MdMsub:  return acc - 64'(sa * sb2);
      default: return acc - ua * ub;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Issue one op, hold start until done (and one cycle past FINISH), count stall cycles.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo,
                        output logic [63:0] res);
    bit ok;
    bit got;
    int lat;
    int stall_cnt;
    exp_t e;
    ok  = supported(op);
    lat = ok ? latency(op, b) : 3;
    res = '0;
    @(negedge clk);
    md_if.start   = 1'b1;
    md_if.annul   = 1'b0;
    md_if.op      = op;
    md_if.opdata1 = a;
    md_if.opdata2 = b;
    md_if.hi_i    = hi;
    md_if.lo_i    = lo;
    if (ok) begin
      e.data = model(op, a, b, hi, lo);
      e.due  = cyc + lat;
      sb.push_back(e);
    end
    got       = 1'b0;
    stall_cnt = 0;
    #1;
    if (md_if.stallreq) stall_cnt++;
    for (int k = 0; k < lat + 2 && !got; k++) begin
      @(negedge clk);
      #1;
      if (md_if.done) begin
        got = 1'b1;
        res = {md_if.result_hi, md_if.result_lo};
      end
      if (md_if.stallreq) stall_cnt++;
    end
    chk($sformatf("done_seen op%0d", op), 64'(got), 64'(ok));
    chk($sformatf("stall_cycles op%0d", op), 64'(stall_cnt), 64'(ok ? lat : 0));
    if (got) begin
      @(negedge clk);
      md_if.start = 1'b0;
      #1;
      chk("no_retrigger_done", 64'(md_if.done), 64'd0);
    end else begin
      md_if.start = 1'b0;
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result on its due cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (md_if.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 expected no pending op at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {md_if.result_hi, md_if.result_lo}, e.data);
          chk("done_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0] r;
    md_op_e rop;
    md_if.start   = 1'b1;
    md_if.annul   = 1'b0;
    md_if.op      = MdMult;
    md_if.opdata1 = 32'd5;
    md_if.opdata2 = 32'd7;
    md_if.hi_i    = 32'd0;
    md_if.lo_i    = 32'd0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_hi", 64'(md_if.result_hi), 64'd0);
    chk("reset_lo", 64'(md_if.result_lo), 64'd0);
    chk("reset_done", 64'(md_if.done), 64'd0);
    chk("reset_stall", 64'(md_if.stallreq), 64'd0);
    @(negedge clk);
    md_if.start = 1'b0;
    rst         = 1'b0;

    run_op(MdMult, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, r);
    chk("mult_literal", r, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(MdMultu, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, r);
    chk("multu_literal", r, 64'h0000_0002_FFFF_FFFA);
    run_op(MdDiv, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, r);
    chk("div_literal", r, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MdDivu, 32'd100, 32'd7, 32'd0, 32'd0, r);
    chk("divu_literal", r, {32'd2, 32'd14});
    run_op(MdDivu, 32'd1234, 32'd0, 32'd0, 32'd0, r);
    chk("div0_literal", r, 64'd0);
    run_op(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, r);
    chk("div_ovf_literal", r, {32'd0, 32'h8000_0000});
    run_op(MdMaddu, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, r);
`ifdef MULDIV_MADD_EN
    chk("maddu_literal", r, 64'h0000_0001_0000_0000);
`endif

    // Annul a divide in flight, then a MULT in the very next cycle.
    @(negedge clk);
    md_if.start   = 1'b1;
    md_if.op      = MdDiv;
    md_if.opdata1 = 32'd1000;
    md_if.opdata2 = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    chk("annul_pre_stall", 64'(md_if.stallreq), 64'd1);
    md_if.annul = 1'b1;
    md_if.start = 1'b0;
    #1;
    chk("annul_stall", 64'(md_if.stallreq), 64'd0);
    run_op(MdMult, 32'd12345, 32'd6789, 32'd0, 32'd0, r);
    chk("post_annul_mult", r, 64'd83810205);

    // Reset in the middle of a divide.
    @(negedge clk);
    md_if.start   = 1'b1;
    md_if.op      = MdDivu;
    md_if.opdata1 = 32'hDEAD_BEEF;
    md_if.opdata2 = 32'd17;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_stall", 64'(md_if.stallreq), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_mid_hi", 64'(md_if.result_hi), 64'd0);
    chk("rst_mid_lo", 64'(md_if.result_lo), 64'd0);
    chk("rst_mid_done", 64'(md_if.done), 64'd0);
    md_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rop = md_op_e'($urandom_range(0, 7));
      run_op(rop, pick(), pick(), $urandom(), $urandom(), r);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
